// File: rtl/fma_pkg.sv
// Shared definitions for the FMA product stage: product word layout,
// exponent limits and the sequential multiplier state encoding.
package fma_pkg;

  localparam int unsigned PROD_W       = 57;
  localparam int unsigned SIGN_POS     = 56;
  localparam int unsigned EXP_HI       = 55;
  localparam int unsigned EXP_LO       = 48;
  localparam int unsigned MANT_HI      = 47;
  localparam int unsigned EXP_W        = 8;
  localparam int unsigned MANT_W       = 48;
  localparam int unsigned OPND_MANT_W  = 24;

  localparam int unsigned EXP_OVF_LIM  = 382;
  localparam int unsigned EXP_UDF_LIM  = 104;
  localparam int unsigned EXP_BIAS_ADJ = 126;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unrounded product word as consumed by the add stage.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } prod_t;

endpackage

// File: rtl/fma_prod_exp.sv
// Product sign/exponent and overflow/underflow classification from the
// sign+exponent fields {sign, exp[7:0]} of both operands.
module fma_prod_exp
  import fma_pkg::*;
(
  input  logic [8:0]       a_se,
  input  logic [8:0]       b_se,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic             ovf,
  output logic             udf
);

  logic [8:0] sum_c;

  // 9-bit sum cannot wrap: max 255 + 255 = 510.
  assign sum_c = {1'b0, a_se[7:0]} + {1'b0, b_se[7:0]};
  assign sign  = a_se[8] ^ b_se[8];
  assign ovf   = sum_c > 9'(EXP_OVF_LIM);
  assign udf   = sum_c < 9'(EXP_UDF_LIM);
  assign exp   = ovf ? 8'hFF
               : udf ? 8'h00
               : 8'(sum_c - 9'(EXP_BIAS_ADJ));

endmodule

// File: rtl/fma_seq_mult.sv
// Sequential radix-2 shift-add 24x24 mantissa multiplier producing the
// unrounded {sign, exp, mant} word for the FMA add stage.
module fma_seq_mult
  import fma_pkg::*;
#(
  parameter int unsigned ITER = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        float_a,
  input  logic [31:0]        float_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PROD_W-1:0]  product
);

  localparam int unsigned CNT_W = $clog2(ITER);

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [MANT_W-1:0]        acc;
  logic [MANT_W-1:0]        mcand;
  logic [OPND_MANT_W-1:0]   mplier;
  logic                     sign_q;
  logic [EXP_W-1:0]         exp_q;
  prod_t                    prod_q;

  logic                     pe_sign_c;
  logic [EXP_W-1:0]         pe_exp_c;
  logic                     pe_ovf_c;
  logic                     pe_udf_c;
  logic [OPND_MANT_W-1:0]   ma_c;
  logic [OPND_MANT_W-1:0]   mb_c;
  logic [MANT_W-1:0]        acc_add_c;

  fma_prod_exp u_prod_exp (
    .a_se (float_a[31:23]),
    .b_se (float_b[31:23]),
    .sign (pe_sign_c),
    .exp  (pe_exp_c),
    .ovf  (pe_ovf_c),
    .udf  (pe_udf_c)
  );

  // Hidden bit restored only for non-zero exponents.
  assign ma_c      = {|float_a[30:23], float_a[22:0]};
  assign mb_c      = {|float_b[30:23], float_b[22:0]};
  assign acc_add_c = mplier[0] ? acc + mcand : acc;
  assign product   = prod_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      prod_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q   <= pe_sign_c;
            exp_q    <= pe_exp_c;
            acc      <= '0;
            mcand    <= MANT_W'(ma_c);
            mplier   <= mb_c;
            cnt      <= '0;
            in_ready <= 1'b0;
            // Out-of-range exponents bypass the loop entirely.
            if (pe_ovf_c || pe_udf_c) begin
              prod_q    <= '{sign: pe_sign_c, exp: pe_exp_c, mant: {MANT_W{pe_ovf_c}}};
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc    <= acc_add_c;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= CNT_W'(cnt + 1'b1);
          if (cnt == CNT_W'(ITER - 1)) begin
            prod_q    <= '{sign: sign_q, exp: exp_q, mant: acc_add_c};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fma_seq_mult.sv
// Self-checking bench for fma_seq_mult: directed literal cases plus random
// back-to-back traffic checked every cycle against a float product model.
module tb_fma_seq_mult;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] float_a;
  logic [31:0] float_b;
  logic        out_valid;
  logic        out_ready;
  logic [56:0] product;

  int          n_tests;
  int          n_fail;
  int          cyc;
  logic [56:0] exp_q[$];
  logic [56:0] prev_prod;
  logic        prev_hold;
  logic        acc_seen;

  fma_seq_mult dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .float_a   (float_a),
    .float_b   (float_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected product word computed from the float fields with plain integers.
  function automatic logic [56:0] model(input logic [31:0] a, input logic [31:0] b);
    int unsigned     ea;
    int unsigned     eb;
    int unsigned     s;
    longint unsigned ma;
    longint unsigned mb;
    logic            sgn;
    logic [47:0]     m;
    logic [7:0]      e;
    ea  = 32'(a[30:23]);
    eb  = 32'(b[30:23]);
    ma  = (ea != 0 ? 64'd8388608 : 64'd0) + 64'(a[22:0]);
    mb  = (eb != 0 ? 64'd8388608 : 64'd0) + 64'(b[22:0]);
    sgn = a[31] ^ b[31];
    s   = ea + eb;
    if (s > 382) return {sgn, 8'hFF, 48'hFFFF_FFFF_FFFF};
    if (s < 104) return {sgn, 56'h0};
    m = 48'(ma * mb);
    e = 8'(s - 126);
    return {sgn, e, m};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle comparison against the model, run at the falling edge.
  task automatic monitor();
    acc_seen = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      prev_hold = 1'b0;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_product", 64'(product), 64'd0);
      return;
    end
    check("ready_valid_excl", 64'(in_ready && out_valid), 64'd0);
    if (prev_hold) begin
      check("hold_product", 64'(product), 64'(prev_prod));
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(float_a, float_b));
      acc_seen = 1'b1;
    end
    if (out_valid) begin
      check("valid_has_pending", 64'(exp_q.size() != 0), 64'd1);
      if (out_ready && exp_q.size() != 0) check("result", 64'(product), 64'(exp_q.pop_front()));
    end
    prev_hold = out_valid && !out_ready;
    prev_prod = product;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present one operand pair for one cycle, then wait for out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [56:0] lit, input string name);
    int cycles;
    float_a  = a;
    float_b  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cycles   = 1;
    while (!out_valid && cycles < 60) begin
      tick();
      cycles++;
    end
    check({name, "_latency"}, 64'(cycles), 64'(lat));
    check({name, "_literal"}, 64'(product), 64'(lit));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int          accepts;
    int          last_acc;
    int          start;
    logic [31:0] ra;
    logic [31:0] rb;
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    prev_hold = 1'b0;
    prev_prod = '0;
    acc_seen  = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    float_a   = '0;
    float_b   = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Model pinned to hand-computed words.
    check("model_1x1", 64'(model(32'h3F800000, 32'h3F800000)), {7'd0, 1'b0, 8'h80, 48'h4000_0000_0000});
    check("model_ovf", 64'(model(32'h7F000000, 32'h7F000000)), {7'd0, 1'b0, 8'hFF, 48'hFFFF_FFFF_FFFF});

    run_op(32'h3F800000, 32'h3F800000, 25, {1'b0, 8'h80, 48'h4000_0000_0000}, "one_x_one");
    drain();

    out_ready = 1'b0;
    run_op(32'h40000000, 32'h40400000, 25, {1'b0, 8'h82, 48'h6000_0000_0000}, "two_x_three");
    in_valid = 1'b1;
    float_a  = 32'h3F800000;
    repeat (5) tick();
    in_valid = 1'b0;
    check("held_literal", 64'(product), {7'd0, 1'b0, 8'h82, 48'h6000_0000_0000});
    drain();

    run_op(32'h7F000000, 32'h7F000000, 1, {1'b0, 8'hFF, 48'hFFFF_FFFF_FFFF}, "overflow");
    drain();
    run_op(32'h00800000, 32'h00800000, 1, {1'b0, 8'h00, 48'h0}, "underflow");
    drain();
    run_op(32'hBFC00000, 32'h40000000, 25, {1'b1, 8'h81, 48'h6000_0000_0000}, "neg_mix");
    drain();

    // Reset in the middle of a BUSY run.
    float_a  = 32'h3F800000;
    float_b  = 32'h3F800000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ready", 64'(in_ready), 64'd1);
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_product", 64'(product), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    start = cyc;
    while (cyc - start < 30) begin
      tick();
      check("post_rst_no_valid", 64'(out_valid), 64'd0);
    end
    run_op(32'h40000000, 32'h40400000, 25, {1'b0, 8'h82, 48'h6000_0000_0000}, "after_reset");
    drain();

    // Back-to-back random normal pairs; operands churn every cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    accepts   = 0;
    last_acc  = 0;
    start     = cyc;
    while (accepts < 50 && cyc - start < 50 * 26 + 100) begin
      ra = {1'($urandom), 8'($urandom_range(191, 52)), 23'($urandom)};
      rb = {1'($urandom), 8'($urandom_range(191, 52)), 23'($urandom)};
      float_a = ra;
      float_b = rb;
      tick();
      if (acc_seen) begin
        if (accepts > 0) check("spacing", 64'(cyc - last_acc), 64'd26);
        last_acc = cyc;
        accepts++;
      end
    end
    check("random_accepts", 64'(accepts), 64'd50);
    in_valid = 1'b0;
    repeat (30) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fma_seq_mult.md
# fma_seq_mult

Sequential, area-reduced replacement for the combinational product stage at the head of the FMA datapath. It accepts two IEEE-754 single-precision operands over a valid/ready handshake and forms the 24x24 mantissa product with a radix-2 shift-add loop. It emits the 57-bit unrounded product word `{sign, exp[7:0], mant[47:0]}` that the FMA add stage consumes.

## Interface
Parameters:
- `ITER`, 24: mantissa width including hidden bit; equals the BUSY cycle count.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block can accept operands.
- `float_a`  in  32  operand A.
- `float_b`  in  32  operand B.
- `out_valid`  out  1  `product` valid.
- `out_ready`  in  1  downstream accepts `product`.
- `product`  out  57  bit 56 is sign, [55:48] is exponent, [47:0] is mantissa product.

## Operation
- Accept when `in_valid && in_ready`. Operands are captured and the special classification is computed from the captured values.
- Field definitions:
  - `ea`, `eb` are 9-bit zero-extended exponents.
  - Hidden bit = (exponent != 0).
  - `ma`, `mb` = {hidden, frac[22:0]}.
- Sign = `a[31] ^ b[31]`.
- Exponent sum `s = ea + eb`, 9 bits with no wrap.
  - Overflow when `s > 382`: result is sign, exp 8'hFF, mantissa all ones.
  - Underflow when `s < 104`: result is sign, exp 0, mantissa 0.
  - Otherwise exp = `(s - 126)[7:0]`.
- Mantissa = `ma * mb`, 48 bits, exact.
  - Registers: 48-bit accumulator (cleared), 48-bit multiplicand = `ma`, 24-bit multiplier = `mb`.
  - Each BUSY cycle: if multiplier[0], accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count += 1.
- State machine:
  - IDLE: `in_ready` = 1. On accept, go to DONE if overflow or underflow, else go to BUSY with count = 0.
  - BUSY: after iteration `ITER-1` (count == 23), go to DONE.
  - DONE: `out_valid` = 1. When `out_ready`, go to IDLE.
- `in_ready` is high only in IDLE. There is no accept in the same cycle as the DONE handshake.
- `product` is registered and held stable while `out_valid && !out_ready`.
- Zero operands are not special-cased. The exponent rule applies as written, and the mantissa is 0 when either hidden bit and fraction are zero.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `product` = 0, state IDLE, count 0.
- Normal latency: accept at edge T, BUSY during T+1..T+24, `out_valid` high after edge T+25.
- Special latency (overflow/underflow): `out_valid` high after edge T+1.
- Throughput is one result per 26 cycles (normal) with `out_ready` held high.
- Asserting `rst_n` low in any state clears everything immediately and asynchronously. The in-flight operation is discarded, and no output appears after reset release.
- `in_valid` while not IDLE is ignored. Operands are not sampled.

## Structure
- Shared package `fma_pkg` holds:
  - `PROD_W` = 57 and field positions SIGN = 56, EXP = 55:48, MANT = 47:0.
  - Constants `EXP_OVF_LIM` = 382, `EXP_UDF_LIM` = 104, `EXP_BIAS_ADJ` = 126.
  - State enum {IDLE, BUSY, DONE}.
- One combinational sub-module, `fma_prod_exp`. It maps (a, b) to sign, 8-bit exponent, overflow, and underflow, so the exponent/special rules live in one place and can be checked against the add-stage expectations.

## Test plan
- 3F800000 x 3F800000 -> after 25 cycles: product sign 0, exp 0x80, mant 0x400000000000.
- 40000000 x 40400000 -> sign 0, exp 0x82, mant 0x600000000000. Then, with `out_ready` low 5 cycles, `product` and `out_valid` remain stable and `in_ready` stays 0.
- BFC00000 x 40000000 -> sign 1, exp 0x81, mant 0x600000000000.
- 7F000000 x 7F000000 -> 1-cycle latency: exp 0xFF, mant 0xFFFFFFFFFFFF. Separately, 00800000 x 00800000 -> 1-cycle latency: exp 0, mant 0.
- Accept 3F800000 x 3F800000, pull `rst_n` low at BUSY cycle 10 for 2 cycles -> outputs are at reset values within the same cycle. After release, no `out_valid` appears, and a new operation completes correctly.
- Back-to-back with `out_ready` high, 50 random normal pairs -> each result matches a reference model, spacing is exactly 26 cycles, and `in_valid` pulses during BUSY are ignored.
